spi_debug_requester: RTL
========================

Name: spi_debug_requester

Overview:
- SPI master that drives the debug SPI link from the initiator end and issues request words in the decode-stage debug request format.
- Request word fields: bits 22:21 select a latch word, bits 20:16 select a register, 0 = latch access.
- Collects the 32-bit responses and presents each one with an index and a one-cycle valid strobe.
- Can sweep the 4 decode-latch words, registers 1..31, both, or a single request.

Parameters:
- NB_BITS, 32, SPI frame and data width
- NB_REG, 5, register index width
- CLK_DIV, 4, system clocks per SCLK half-period (>=1)
- GAP_CYCLES, 8, cycles CS_n held high between frames (>=2)

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  start a transaction; sampled only in IDLE
- i_mode  in  2  00 latch words 0..3; 01 regs 1..31; 10 latch then regs; 11 single
- i_single_req  in  7  {latch_sel[1:0], reg[4:0]}; used when i_mode=11
- o_sclk  out  1  SPI clock, mode 0 (idle low)
- o_cs_n  out  1  SPI chip select, active low
- o_mosi  out  1  master out, MSB first
- i_miso  in  1  master in, MSB first
- o_data  out  NB_BITS  response word
- o_index  out  6  {is_reg, idx[4:0]}; latch word k gives {0, k}; register r gives {1, r}
- o_valid  out  1  one-cycle strobe, o_data and o_index valid
- o_busy  out  1  high from the cycle after an accepted start until DONE exits
- o_done  out  1  one-cycle pulse at the end of a transaction

Behaviour:
- Reset (i_reset=0 at a clock edge):
  - o_cs_n=1, o_sclk=0, o_mosi=0, o_data=0, o_index=0.
  - o_valid=0, o_busy=0, o_done=0; FSM goes to IDLE; counters cleared.
- Reset mid-frame aborts immediately; no valid or done is produced.
- Request word = {9'b0, sel[1:0], reg[4:0], 16'b0}.
  - Latch word k: sel=k, reg=0.
  - Register r: sel=00, reg=r.
  - Flush frame: request word 32'h0.
- Pipeline rule: the slave returns the response to frame N during frame N+1.
  - A transaction of R requests uses R+1 frames.
  - Frame 0's received word is discarded.
  - The last frame carries the flush request.
- R per mode: 4 (00), 31 (01), 35 (10), 1 (11).
- Mode 11 index: reg≠0 gives {1, reg}; reg=0 gives {0, sel}.
- FSM states and transitions:
  - IDLE: cs_n=1. On i_start=1, latch i_mode and i_single_req, load the first request, go to SETUP. o_busy=1 from the next cycle.
  - SETUP: cs_n=0, sclk=0, mosi=tx[31]. Hold CLK_DIV cycles, then go to SHIFT.
  - SHIFT: sclk toggles every CLK_DIV cycles.
    - On each rising SCLK transition, shift i_miso into rx[0].
    - On each falling transition, shift tx left and drive the next bit.
    - After the 32nd rising edge plus one half-period low, go to GAP.
    - Bit counter is 0..31 and never wraps within a frame.
  - GAP: cs_n=1.
    - In the first GAP cycle, if frame index>0: o_data=rx, o_index = index of the previous request, o_valid=1 for exactly one cycle.
    - After GAP_CYCLES: if frames remain, load the next request word and go to SETUP; else go to DONE.
  - DONE: o_done=1 for one cycle, o_busy=0 from the next cycle, go to IDLE.
- Frame length: 2*CLK_DIV*33 clocks from cs_n falling to cs_n rising (setup half-period plus 32 bit periods plus final low half).
- i_start while busy is ignored, with no queuing.
- i_start held high across DONE to IDLE starts a new transaction on the first IDLE cycle.
- Mode 10 index order: {0,0}..{0,3}, then {1,1}..{1,31}.
- The valid strobe for the last request appears in the GAP after the flush frame, before o_done.

Decomposition:
- Shared package dbg_spi_pkg holds:
  - field positions REQ_SEL_HI=22, REQ_SEL_LO=21, REQ_REG_HI=20, REQ_REG_LO=16;
  - latch selects GET_PC_4=00, GET_RS_REG=01, GET_RT_REG=10, GET_SIGN_EXT=11;
  - mode encodings;
  - FSM state encoding.
- One natural sub-module: spi_master_shifter.
  - Covers SETUP and SHIFT: SCLK divider, 32-bit tx/rx shift registers, frame_start input, frame_done pulse.
  - The parent keeps request sequencing, the response pipeline and the index tracking.

Test Plan:
- Mode 00, slave model returns 32'hA0000000+k for latch word k.
  - Expect 5 frames, with MOSI words 0x00000000, 0x00200000, 0x00400000, 0x00600000, 0x0.
  - Expect 4 valids with (index, data) = ({0,k}, 0xA000000k), then o_done 1 cycle.
- Mode 01, slave returns 0x100+r.
  - Expect 32 frames and 31 valids, indices {1,1}..{1,31}, data 0x101..0x11F in order.
  - Expect no valid after frame 0.
- Mode 11, i_single_req=7'b00_00111, slave returns 0xDEADBEEF.
  - Expect 2 frames, first MOSI word 0x00070000.
  - Expect one valid with index 6'b100111, data 0xDEADBEEF.
- i_start pulsed during SHIFT of mode 00: expect no extra frames and exactly 4 valids.
  - i_start held high through DONE: expect a second transaction beginning on the next IDLE cycle.
- Reset asserted at bit 15 of frame 2: next cycle cs_n=1, sclk=0, busy=0; no valid and no done follow.
- CLK_DIV=1, GAP_CYCLES=2: frame length is 66 clocks, and all mode 00 data matches.

Source files
------------

// File: rtl/dbg_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbg_spi_pkg
// Brief    : Debug SPI request-word layout, modes, FSM encoding and helpers.
// Revision : 1.0
// ============================================================================
package dbg_spi_pkg;

    localparam int REQ_SEL_HI = 22;
    localparam int REQ_SEL_LO = 21;
    localparam int REQ_REG_HI = 20;
    localparam int REQ_REG_LO = 16;

    localparam logic [1:0] GET_PC_4     = 2'b00;
    localparam logic [1:0] GET_RS_REG   = 2'b01;
    localparam logic [1:0] GET_RT_REG   = 2'b10;
    localparam logic [1:0] GET_SIGN_EXT = 2'b11;

    localparam logic [1:0] MODE_LATCH  = 2'b00;
    localparam logic [1:0] MODE_REGS   = 2'b01;
    localparam logic [1:0] MODE_BOTH   = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic [5:0] req_count(input logic [1:0] mode);
        logic [5:0] n;
        case (mode)
            MODE_LATCH: n = 6'd4;
            MODE_REGS:  n = 6'd31;
            MODE_BOTH:  n = 6'd35;
            default:    n = 6'd1;
        endcase
        return n;
    endfunction

    // {sel, reg} of request number n within a sweep
    function automatic logic [6:0] req_fields(input logic [1:0] mode,
                                              input logic [6:0] single,
                                              input logic [5:0] n);
        logic [6:0] f;
        case (mode)
            MODE_LATCH: f = {n[1:0], 5'd0};
            MODE_REGS:  f = {GET_PC_4, 5'(n + 6'd1)};
            MODE_BOTH:  f = (n < 6'd4) ? {n[1:0], 5'd0} : {GET_PC_4, 5'(n - 6'd3)};
            default:    f = single;
        endcase
        return f;
    endfunction

    function automatic logic [5:0] field_index(input logic [6:0] f);
        if (f[4:0] != 5'd0) begin
            return {1'b1, f[4:0]};
        end
        return {4'b0000, f[6:5]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_shifter
// Brief    : One mode-0 SPI frame: setup half, 32 bit periods, trailing low half.
// Revision : 1.0
// ============================================================================
module spi_master_shifter #(
    parameter int NB_BITS = 32,
    parameter int CLK_DIV = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_frame_start,
    input  logic [NB_BITS-1:0] i_tx_word,
    input  logic               i_miso,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic [NB_BITS-1:0] o_rx_word,
    output logic               o_setup_done,
    output logic               o_frame_done
);

    localparam int HALVES = 2 * NB_BITS + 2;
    localparam int HW     = $clog2(HALVES);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic               active_q;
    logic [DW-1:0]      div_q;
    logic [HW-1:0]      half_q;
    logic [NB_BITS-1:0] tx_q;
    logic [NB_BITS-1:0] rx_q;
    logic               sclk_q;
    logic               mosi_q;

    logic               w_div_end;
    logic               w_last_half;
    logic               w_rise;
    logic               w_fall;
    logic [HW-1:0]      w_half_nx;

    // Half 0 is setup; odd halves are SCLK high; the final two halves stay low
    assign w_div_end   = (div_q == DW'(CLK_DIV - 1));
    assign w_last_half = (half_q == HW'(HALVES - 1));
    assign w_half_nx   = half_q + HW'(1);
    assign w_rise      = w_half_nx[0] && (w_half_nx < HW'(2 * NB_BITS));
    assign w_fall      = !w_half_nx[0] && (w_half_nx <= HW'(2 * NB_BITS));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else if (i_frame_start) begin
            active_q <= 1'b1;
            div_q    <= '0;
            half_q   <= '0;
            tx_q     <= i_tx_word;
            mosi_q   <= i_tx_word[NB_BITS-1];
            sclk_q   <= 1'b0;
        end else if (active_q) begin
            if (!w_div_end) begin
                div_q <= div_q + DW'(1);
            end else begin
                div_q <= '0;
                if (w_last_half) begin
                    active_q <= 1'b0;
                end else begin
                    half_q <= w_half_nx;
                    if (w_rise) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[NB_BITS-2:0], i_miso};
                    end
                    if (w_fall) begin
                        sclk_q <= 1'b0;
                        tx_q   <= {tx_q[NB_BITS-2:0], 1'b0};
                        mosi_q <= tx_q[NB_BITS-2];
                    end
                end
            end
        end
    end

    assign o_sclk       = sclk_q;
    assign o_mosi       = mosi_q;
    assign o_rx_word    = rx_q;
    assign o_setup_done = active_q && w_div_end && (half_q == '0);
    assign o_frame_done = active_q && w_div_end && w_last_half;

endmodule
`default_nettype wire

// File: rtl/spi_debug_requester.sv
`default_nettype none
// ============================================================================
// Module   : spi_debug_requester
// Brief    : Debug SPI initiator: sweeps requests, returns pipelined responses.
// Revision : 1.0
// ============================================================================
module spi_debug_requester
    import dbg_spi_pkg::*;
#(
    parameter int NB_BITS    = 32,
    parameter int NB_REG     = 5,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [1:0]         i_mode,
    input  logic [NB_REG+1:0]  i_single_req,
    output logic               o_sclk,
    output logic               o_cs_n,
    output logic               o_mosi,
    input  logic               i_miso,
    output logic [NB_BITS-1:0] o_data,
    output logic [NB_REG:0]    o_index,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [2:0]         state_q,  state_d;
    logic [1:0]         mode_q,   mode_d;
    logic [NB_REG+1:0]  single_q, single_d;
    logic [5:0]         frame_q,  frame_d;
    logic [GW-1:0]      gap_q,    gap_d;
    logic               cs_n_q,   cs_n_d;
    logic               valid_q,  valid_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [NB_BITS-1:0] data_q,   data_d;
    logic [NB_REG:0]    index_q,  index_d;

    logic               w_frame_start;
    logic               w_setup_done;
    logic               w_frame_done;
    logic [1:0]         w_mode;
    logic [NB_REG+1:0]  w_single;
    logic [5:0]         w_next_n;
    logic [NB_BITS-1:0] w_tx_word;
    logic [NB_BITS-1:0] w_rx_word;

    // In IDLE the first request is built from the live inputs being latched
    always_comb begin
        w_mode    = (state_q == ST_IDLE) ? i_mode : mode_q;
        w_single  = (state_q == ST_IDLE) ? i_single_req : single_q;
        w_next_n  = (state_q == ST_IDLE) ? 6'd0 : frame_q + 6'd1;
        w_tx_word = '0;
        if (w_next_n != req_count(w_mode)) begin
            w_tx_word[REQ_SEL_HI:REQ_REG_LO] = req_fields(w_mode, w_single, w_next_n);
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        single_d      = single_q;
        frame_d       = frame_q;
        gap_d         = gap_q;
        cs_n_d        = cs_n_q;
        valid_d       = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        data_d        = data_q;
        index_d       = index_q;
        w_frame_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d        = i_mode;
                    single_d      = i_single_req;
                    frame_d       = 6'd0;
                    cs_n_d        = 1'b0;
                    busy_d        = 1'b1;
                    w_frame_start = 1'b1;
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_setup_done) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_frame_done) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    gap_d   = '0;
                    // Response of frame N belongs to the request of frame N-1
                    if (frame_q != 6'd0) begin
                        valid_d = 1'b1;
                        data_d  = w_rx_word;
                        index_d = field_index(req_fields(mode_q, single_q, frame_q - 6'd1));
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (frame_q < req_count(mode_q)) begin
                        frame_d       = frame_q + 6'd1;
                        cs_n_d        = 1'b0;
                        w_frame_start = 1'b1;
                        state_d       = ST_SETUP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'b00;
            single_q <= '0;
            frame_q  <= 6'd0;
            gap_q    <= '0;
            cs_n_q   <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            single_q <= single_d;
            frame_q  <= frame_d;
            gap_q    <= gap_d;
            cs_n_q   <= cs_n_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            index_q  <= index_d;
        end
    end

    spi_master_shifter #(
        .NB_BITS (NB_BITS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_frame_start (w_frame_start),
        .i_tx_word     (w_tx_word),
        .i_miso        (i_miso),
        .o_sclk        (o_sclk),
        .o_mosi        (o_mosi),
        .o_rx_word     (w_rx_word),
        .o_setup_done  (w_setup_done),
        .o_frame_done  (w_frame_done)
    );

    assign o_cs_n  = cs_n_q;
    assign o_data  = data_q;
    assign o_index = index_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
`default_nettype wire
